segment_scanner: RTL and testbench

SEGMENT_SCANNER -- requirements
Module: segment_scanner

---
 rtl/segment_scanner_if.sv | 24 ++
 rtl/segment_scanner.sv | 115 +++++++++++
 tb/tb_segment_scanner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/segment_scanner_if.sv
// Display-side bundle of the multiplexed seven-segment scanner: digit data in,
// active-low anode/cathode/dp drive and frame pulse out.
interface segment_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   point;
    logic                blank_zero;
    logic [2:0]          brightness;
    logic [DIGITS-1:0]   anode;
    logic [6:0]          cathode;
    logic                dp;
    logic                frame;

    modport master (
        output digits, point, blank_zero, brightness,
        input  anode, cathode, dp, frame
    );

    modport slave (
        input  digits, point, blank_zero, brightness,
        output anode, cathode, dp, frame
    );
endinterface

// File: rtl/segment_scanner.sv
// Time-multiplexed hex seven-segment scanner with per-frame shadowed data,
// leading-zero blanking and eighth-step brightness control.
module segment_scanner #(
    parameter int DIGITS = 4,
    parameter int DIVIDE = 2048
) (
    input logic               clock,
    input logic               reset,
    segment_scanner_if.slave  bus
);
    localparam int PW    = $clog2(DIVIDE);
    localparam int IW    = $clog2(DIGITS);
    localparam int TW    = PW + 1;
    localparam int SLOT8 = DIVIDE / 8;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           index;
    logic [DIGITS-1:0][3:0]  shadow_digits;
    logic [DIGITS-1:0]       shadow_point;
    logic                    load_pending;

    logic [DIGITS-1:0]       content;
    logic [DIGITS-1:0]       blank_lane;
    logic                    slot_end;
    logic                    scan_end;
    logic [TW-1:0]           on_limit;
    logic                    lit;
    logic [6:0]              segments;

    logic [DIGITS-1:0]       anode_q;
    logic [6:0]              cathode_q;
    logic                    dp_q;
    logic                    frame_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    assign slot_end = (prescaler == PW'(DIVIDE - 1));
    assign scan_end = slot_end && (index == IW'(DIGITS - 1));

    // A digit is blanked only if it and everything to its left is an empty zero.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_lane
            assign content[g] = (|shadow_digits[g]) | shadow_point[g];
            if (g == 0) begin : g_first
                assign blank_lane[g] = 1'b0;
            end else begin : g_upper
                assign blank_lane[g] = bus.blank_zero & ~(|content[DIGITS-1:g]);
            end
        end
    endgenerate

    // brightness=7 gives a limit of DIVIDE, so the digit stays lit all slot.
    assign on_limit = (TW'(bus.brightness) + TW'(1)) * TW'(SLOT8);
    assign lit      = ~blank_lane[index] && ({1'b0, prescaler} < on_limit);
    assign segments = hex_to_seg(shadow_digits[index]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler     <= '0;
            index         <= '0;
            shadow_digits <= '0;
            shadow_point  <= '0;
            load_pending  <= 1'b1;
        end else begin
            prescaler    <= slot_end ? '0 : prescaler + 1'b1;
            load_pending <= 1'b0;
            if (slot_end)
                index <= scan_end ? '0 : index + 1'b1;
            // Data only changes between scans so one frame never mixes old and new.
            if (scan_end || load_pending) begin
                shadow_digits <= bus.digits;
                shadow_point  <= bus.point;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode_q   <= '1;
            cathode_q <= 7'b1111111;
            dp_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            anode_q   <= lit ? ~(DIGITS'(1) << index) : '1;
            cathode_q <= lit ? segments : 7'b1111111;
            dp_q      <= lit ? ~shadow_point[index] : 1'b1;
            frame_q   <= scan_end;
        end
    end

    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;
    assign bus.dp      = dp_q;
    assign bus.frame   = frame_q;
endmodule

// File: tb/tb_segment_scanner.sv
// Directed scoreboard bench for segment_scanner with DIGITS=4, DIVIDE=8.
module tb_segment_scanner;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       dp;
        logic       frame;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];

    always #5 clock = ~clock;

    segment_scanner_if #(.DIGITS(4)) bus ();

    segment_scanner #(.DIGITS(4), .DIVIDE(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // One full scan of expectations: slot s shows segs for 'on' of 8 cycles.
    task automatic push_scan(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] blank, input logic [3:0] pt,
                             input int on);
        logic [6:0] segs [4];
        exp_t       e;
        logic [3:0] one_hot;
        logic       lit;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int s = 0; s < 4; s++) begin
            one_hot = 4'b0001 << s;
            for (int p = 0; p < 8; p++) begin
                lit       = !blank[s] && (p < on);
                e.anode   = lit ? ~one_hot : 4'b1111;
                e.cathode = lit ? segs[s] : 7'b1111111;
                e.dp      = lit ? ~pt[s] : 1'b1;
                e.frame   = (s == 3 && p == 7);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_n(input int n, input string tag,
                           input int change_at, input logic [15:0] new_digits);
        exp_t e;
        exp_t obs;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (k == change_at) bus.digits = new_digits;
            if (q.size() == 0) begin
                checks++; fails++;
                $error("FAIL %s k=%0d scoreboard empty", tag, k);
                break;
            end
            e   = q.pop_front();
            obs = {bus.anode, bus.cathode, bus.dp, bus.frame};
            checks++;
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s k=%0d observed anode=%b cathode=%b dp=%b frame=%b expected anode=%b cathode=%b dp=%b frame=%b",
                       tag, k, obs.anode, obs.cathode, obs.dp, obs.frame,
                       e.anode, e.cathode, e.dp, e.frame);
            end
            checks++;
            assert ($countones(~bus.anode) <= 1) else begin
                fails++;
                $error("FAIL %s_onehot k=%0d observed anode=%b expected at most one low", tag, k, bus.anode);
            end
        end
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.frame !== 1'b1 && n < 200);
        checks++;
        assert (bus.frame === 1'b1) else begin
            fails++;
            $error("FAIL %s frame observed=%b expected=1 within 200 cycles", tag, bus.frame);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t obs;
        obs = {bus.anode, bus.cathode, bus.dp, bus.frame};
        checks++;
        assert (obs === {4'b1111, 7'b1111111, 1'b1, 1'b0}) else begin
            fails++;
            $error("FAIL %s observed anode=%b cathode=%b dp=%b frame=%b expected 1111/1111111/1/0",
                   tag, obs.anode, obs.cathode, obs.dp, obs.frame);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.digits     = 16'h1234;
        bus.point      = 4'b0000;
        bus.blank_zero = 1'b0;
        bus.brightness = 3'd7;
        #12;
        check_reset_outputs("reset_initial");
        @(negedge clock);
        reset = 1'b0;

        // Full brightness 1234, two scans back to back to see the 32-cycle frame.
        wait_frame("sync_1234");
        push_scan(S1, S2, S3, S4, 4'b0000, 4'b0000, 8);
        push_scan(S1, S2, S3, S4, 4'b0000, 4'b0000, 8);
        check_n(64, "hex1234", -1, 16'h0);

        // Leading-zero blanking, then blanking off takes effect without a reload.
        bus.digits     = 16'h0050;
        bus.blank_zero = 1'b1;
        wait_frame("sync_0050");
        push_scan(S0, S0, S5, S0, 4'b1100, 4'b0000, 8);
        check_n(32, "blank_on_0050", -1, 16'h0);
        bus.blank_zero = 1'b0;
        push_scan(S0, S0, S5, S0, 4'b0000, 4'b0000, 8);
        check_n(32, "blank_off_0050", -1, 16'h0);

        // Brightness 1: two lit cycles per slot.
        bus.digits     = 16'h1234;
        bus.brightness = 3'd1;
        wait_frame("sync_dim");
        push_scan(S1, S2, S3, S4, 4'b0000, 4'b0000, 2);
        check_n(32, "bright1", -1, 16'h0);

        // Data change mid-scan stays hidden until the next frame.
        bus.brightness = 3'd7;
        bus.digits     = 16'h1111;
        wait_frame("sync_1111");
        push_scan(S1, S1, S1, S1, 4'b0000, 4'b0000, 8);
        push_scan(S2, S2, S2, S2, 4'b0000, 4'b0000, 8);
        check_n(64, "shadow_2222", 10, 16'h2222);

        // Decimal point keeps an otherwise-zero digit from blanking.
        bus.digits     = 16'h0000;
        bus.point      = 4'b0100;
        bus.blank_zero = 1'b1;
        wait_frame("sync_point");
        push_scan(S0, S0, S0, S0, 4'b1000, 4'b0100, 8);
        check_n(32, "point_0100", -1, 16'h0);

        // Asynchronous reset during slot 2.
        bus.point      = 4'b0000;
        bus.blank_zero = 1'b0;
        bus.digits     = 16'h1234;
        wait_frame("sync_reset");
        repeat (17) @(negedge clock);
        @(posedge clock);
        #2;
        checks++;
        assert (bus.anode === 4'b1011) else begin
            fails++;
            $error("FAIL pre_reset_idx2 observed anode=%b expected 1011", bus.anode);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clock);
        check_reset_outputs("reset_held");
        @(negedge clock);
        reset = 1'b0;
        // The first cycle after release still shows the cleared shadow (digit 0 = '0').
        push_scan(S1, S2, S3, S4, 4'b0000, 4'b0000, 8);
        q[0] = {4'b1110, S0, 1'b1, 1'b0};
        check_n(32, "after_reset", -1, 16'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
